// File: rtl/hamming_secded_codec.sv
// Pipelined, parametrised Hamming SECDED codec. Each word carries its own
// encode/decode mode through a 2-stage elastic pipeline with saturating error counters.
module hamming_secded_codec #(
  parameter int P_W = 4,
  parameter int CNT_W = 16,
  localparam int CODE_W = 2 ** P_W,
  localparam int DATA_W = CODE_W - P_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [CODE_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_word,
  output logic              out_mode,
  output logic              out_corr,
  output logic              out_dbl,
  output logic [P_W-1:0]    out_syn,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_dbl
);

  // Data bits occupy the non-power-of-two positions >= 3, data bit 0 lowest.
  function automatic logic [CODE_W-1:0] place(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] w;
    logic [DATA_W-1:0] dd;
    w  = '0;
    dd = d;
    for (int i = 3; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        w  = w | (CODE_W'(dd[0]) << i);
        dd = dd >> 1;
      end
    end
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] w);
    logic [DATA_W-1:0] d;
    logic [CODE_W-1:0] ws;
    int j;
    d = '0;
    j = 0;
    for (int i = 3; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        ws = w >> i;
        if (ws[0]) d = d | (DATA_W'(1) << j);
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [P_W-1:0] syndrome(input logic [CODE_W-1:0] w);
    logic [P_W-1:0]    s;
    logic [CODE_W-1:0] ws;
    s = '0;
    for (int i = 1; i < CODE_W; i++) begin
      ws = w >> i;
      if (ws[0]) s = s ^ P_W'(i);
    end
    return s;
  endfunction

  // Handshake: a word moves on a clock edge where valid && ready on that side.
  // The whole pipeline advances together when the output register is empty or
  // being drained; otherwise every stage holds its contents.
  logic adv;
  logic accept;
  logic [CODE_W-1:0] in_cw;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;
  assign accept   = in_valid && in_ready;
  assign in_cw    = in_mode ? in_word : place(in_word[DATA_W-1:0]);

  logic              s1_valid;
  logic              s1_mode;
  logic              s1_par;
  logic [CODE_W-1:0] s1_word;
  logic [P_W-1:0]    s1_syn;

  // For encode, the syndrome of the placed data is exactly the Hamming parity vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_par   <= 1'b0;
      s1_word  <= '0;
      s1_syn   <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_mode <= in_mode;
        s1_word <= in_cw;
        s1_syn  <= syndrome(in_cw);
        s1_par  <= ^in_cw;
      end
    end
  end

  logic [CODE_W-1:0] enc_cw;
  logic [CODE_W-1:0] fix_cw;
  logic [P_W-1:0]    sh;
  logic              dec_dbl;

  always_comb begin
    enc_cw = s1_word;
    sh     = '0;
    for (int k = 0; k < P_W; k++) begin
      sh = s1_syn >> k;
      if (sh[0]) enc_cw = enc_cw | (CODE_W'(1) << (2 ** k));
    end
    // Overall parity covers data bits (s1_par) plus the Hamming bits just inserted.
    enc_cw[0] = s1_par ^ (^s1_syn);
    fix_cw    = s1_word ^ (CODE_W'(s1_par) << s1_syn);
    dec_dbl   = !s1_par && (s1_syn != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_mode  <= 1'b0;
      out_corr  <= 1'b0;
      out_dbl   <= 1'b0;
      out_syn   <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mode <= s1_mode;
        out_word <= s1_mode ? CODE_W'(extract(fix_cw)) : enc_cw;
        out_corr <= s1_mode && s1_par;
        out_dbl  <= s1_mode && dec_dbl;
        out_syn  <= s1_mode ? s1_syn : '0;
      end
    end
  end

  logic xfer;
  assign xfer = out_valid && out_ready && out_mode;

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_corr <= '0;
      cnt_dbl  <= '0;
    end else if (xfer) begin
      if (out_corr && (cnt_corr != '1)) cnt_corr <= cnt_corr + CNT_W'(1);
      if (out_dbl && (cnt_dbl != '1))   cnt_dbl  <= cnt_dbl + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed testbench for hamming_secded_codec (P_W=4, CNT_W=2): hand-computed
// codewords, expected-queue scoreboard, backpressure, saturation and mid-flight reset.
module tb_hamming_secded_codec;
  localparam int P_W = 4;
  localparam int CNT_W = 2;
  localparam int CODE_W = 16;

  typedef struct packed {
    logic        mode;
    logic [15:0] word;
    logic        corr;
    logic        dbl;
    logic [3:0]  syn;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CODE_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_word;
  logic              out_mode;
  logic              out_corr;
  logic              out_dbl;
  logic [P_W-1:0]    out_syn;
  logic              clr_cnt;
  logic [CNT_W-1:0]  cnt_corr;
  logic [CNT_W-1:0]  cnt_dbl;

  hamming_secded_codec #(.P_W(P_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_mode(out_mode),
    .out_corr(out_corr), .out_dbl(out_dbl), .out_syn(out_syn),
    .clr_cnt(clr_cnt), .cnt_corr(cnt_corr), .cnt_dbl(cnt_dbl)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_tests = 0;
  int n_fail = 0;
  logic [EXP_W-1:0] exp_q[$];
  int acc_q[$];
  logic chk_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t enc(input logic [15:0] cw);
    exp_t e;
    e.mode = 1'b0; e.word = cw; e.corr = 1'b0; e.dbl = 1'b0; e.syn = 4'h0;
    return e;
  endfunction

  function automatic exp_t dec(input logic [15:0] data, input logic corr,
                               input logic dbl, input logic [3:0] syn);
    exp_t e;
    e.mode = 1'b1; e.word = data; e.corr = corr; e.dbl = dbl; e.syn = syn;
    return e;
  endfunction

  // driver tasks
  task automatic send(input logic mode, input logic [15:0] word, input exp_t e);
    int guard = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_word  = word;
    exp_q.push_back(e);
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // output monitor
  exp_t mon_e;
  int   mon_a;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_out", 32'd1, 32'd0);
      end else begin
        mon_e = exp_t'(exp_q.pop_front());
        mon_a = acc_q.pop_front();
        check("out_mode", out_mode, mon_e.mode);
        check("out_word", out_word, mon_e.word);
        check("out_corr", out_corr, mon_e.corr);
        check("out_dbl", out_dbl, mon_e.dbl);
        check("out_syn", out_syn, mon_e.syn);
        if (chk_lat) check("latency", cyc - mon_a, 32'd2);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_word = '0;
    out_ready = 1'b1; clr_cnt = 1'b0; chk_lat = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_flags", {out_mode, out_corr, out_dbl, out_syn}, 0);
    check("rst_cnt", {cnt_corr, cnt_dbl}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // basic encode / decode
    send(1'b0, 16'h0001, enc(16'h000F));
    send(1'b0, 16'h0000, enc(16'h0000));
    drain();
    send(1'b1, 16'h000F, dec(16'h0001, 1'b0, 1'b0, 4'd0));
    send(1'b1, 16'h010F, dec(16'h0001, 1'b1, 1'b0, 4'd8));
    drain();
    @(negedge clk);
    check("cnt_corr_1", cnt_corr, 1);
    check("cnt_dbl_0", cnt_dbl, 0);
    @(posedge clk); #1;
    send(1'b1, 16'h000E, dec(16'h0001, 1'b1, 1'b0, 4'd0));
    send(1'b1, 16'h000C, dec(16'h0001, 1'b0, 1'b1, 4'd1));
    drain();
    @(negedge clk);
    check("cnt_corr_2", cnt_corr, 2);
    check("cnt_dbl_1", cnt_dbl, 1);
    @(posedge clk); #1;

    // more patterns: all-ones data, ignored upper bits, top data bit, errors on it
    send(1'b0, 16'h07FF, enc(16'hFFFF));
    send(1'b0, 16'hF800, enc(16'h0000));
    send(1'b0, 16'h0400, enc(16'h8117));
    send(1'b1, 16'hFFFF, dec(16'h07FF, 1'b0, 1'b0, 4'd0));
    send(1'b1, 16'h8137, dec(16'h0400, 1'b1, 1'b0, 4'd5));
    send(1'b1, 16'h0116, dec(16'h0000, 1'b0, 1'b1, 4'd15));
    drain();
    @(negedge clk);
    check("cnt_corr_3", cnt_corr, 3);
    check("cnt_dbl_2", cnt_dbl, 2);
    @(posedge clk); #1;

    // counter clear and saturation
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_cnt", {cnt_corr, cnt_dbl}, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send(1'b1, 16'h010F, dec(16'h0001, 1'b1, 1'b0, 4'd8));
    drain();
    @(negedge clk);
    check("cnt_corr_sat", cnt_corr, 3);
    check("cnt_dbl_sat0", cnt_dbl, 0);
    @(posedge clk); #1;
    send(1'b1, 16'h010F, dec(16'h0001, 1'b1, 1'b0, 4'd8));
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_with_incr", cnt_corr, 0);
    @(posedge clk); #1;
    drain();

    // backpressure
    out_ready = 1'b0;
    chk_lat = 1'b0;
    fork
      begin
        send(1'b0, 16'h0001, enc(16'h000F));
        send(1'b0, 16'h0400, enc(16'h8117));
        send(1'b1, 16'h000F, dec(16'h0001, 1'b0, 1'b0, 4'd0));
        send(1'b1, 16'hFFFF, dec(16'h07FF, 1'b0, 1'b0, 4'd0));
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_word", out_word, 16'h000F);
        repeat (3) @(negedge clk);
        check("bp_hold_word", out_word, 16'h000F);
        check("bp_hold_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk_lat = 1'b1;
    @(negedge clk);
    check("idle_after_bp", out_valid, 0);
    @(posedge clk); #1;

    // reset with words in flight
    send(1'b1, 16'h010F, dec(16'h0001, 1'b1, 1'b0, 4'd8));
    drain();
    @(negedge clk);
    check("cnt_before_rst", cnt_corr, 1);
    @(posedge clk); #1;
    send(1'b1, 16'h010F, dec(16'h0001, 1'b1, 1'b0, 4'd8));
    send(1'b1, 16'h000C, dec(16'h0001, 1'b0, 1'b1, 4'd1));
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_word", out_word, 0);
    check("midrst_flags", {out_mode, out_corr, out_dbl, out_syn}, 0);
    check("midrst_cnt", {cnt_corr, cnt_dbl}, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(1'b0, 16'h0400, enc(16'h8117));
    send(1'b1, 16'h8137, dec(16'h0400, 1'b1, 1'b0, 4'd5));
    drain();
    @(negedge clk);
    check("post_rst_cnt", cnt_corr, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_secded_codec.md
Name: hamming_secded_codec

Overview:
- Parametrised, pipelined Hamming SECDED encoder/decoder for the channel-coding datapath. It succeeds the fixed 16-bit combinational encoder/decoder.
- Each accepted word carries its own mode bit (encode or decode). Words flow through a 2-stage elastic pipeline with valid/ready handshakes on both sides.
- Saturating error counters support link-quality reporting.

Parameters:
- P_W, 4: Hamming parity-bit count. CODE_W = 2**P_W (16). DATA_W = CODE_W - P_W - 1 (11). Legal range 3..6.
- CNT_W, 16: width of each error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word this cycle.
- in_mode  in  1  0 = encode, 1 = decode; sampled with the word.
- in_word  in  CODE_W  encode uses [DATA_W-1:0] and ignores the upper bits; decode uses the full codeword.
- out_valid  out  1  output word present.
- out_ready  in  1  downstream accepts.
- out_word  out  CODE_W  encode: codeword; decode: data in [DATA_W-1:0], upper bits 0.
- out_mode  out  1  mode of the word on out_word.
- out_corr  out  1  decode: single error corrected.
- out_dbl  out  1  decode: uncorrectable double error.
- out_syn  out  P_W  decode: Hamming syndrome; 0 in encode mode.
- clr_cnt  in  1  synchronous counter clear.
- cnt_corr  out  CNT_W  count of corrected words delivered.
- cnt_dbl  out  CNT_W  count of double-error words delivered.

Behaviour:
- Codeword layout:
  - Bit 0 is overall even parity: XOR of bits 1..CODE_W-1.
  - Bits at power-of-two positions 1, 2, 4, ... are Hamming parity. Parity bit 2^k = XOR of all positions i > 0 with i[k] = 1, excluding itself.
  - Data bits fill the remaining positions in ascending order, data bit 0 in the lowest (position 3).
- Decode:
  - s = XOR of indices i (i >= 1) where bit i = 1; p = XOR of all CODE_W bits.
  - s = 0, p = 0: clean.
  - p = 1: single error at position s (s = 0 means bit 0). Flip that bit, set out_corr.
  - s != 0, p = 0: set out_dbl; output data extracted uncorrected.
  - out_corr and out_dbl are never both 1.
- Pipeline:
  - Stage 1 registers the word and mode and computes the parity bits (encode) or s/p (decode).
  - Stage 2 registers the assembled codeword or corrected/extracted data plus flags.
  - Latency is exactly 2 cycles from the accepting edge to out_valid with no backpressure. Throughput is 1 word/cycle.
- Handshake:
  - adv = !out_valid || out_ready.
  - in_ready = adv && !rst (combinational); a word is accepted when in_valid && in_ready.
  - When adv = 0 the whole pipeline holds: out_* stable, no word dropped or duplicated, order preserved.
  - Bubbles are propagated as invalid; no bubble compaction is required.
- Counters:
  - Increment on an output transfer (out_valid && out_ready && out_mode = 1) when the matching flag is set.
  - Saturate at 2**CNT_W - 1.
  - clr_cnt zeroes both counters. clr_cnt in the same cycle as an increment yields 0.
- Reset, including mid-operation:
  - Pipeline valids clear and in-flight words are discarded.
  - out_valid = 0; out_word, out_mode, out_corr, out_dbl, out_syn = 0.
  - Both counters = 0. in_ready = 0 while rst is high and 1 in the first cycle after.
- Encode-mode outputs: out_corr = out_dbl = 0, out_syn = 0.

Test Plan:
- Encode, P_W=4, out_ready=1: in_word 16'h0001 then 16'h0000 -> out_word 16'h000F then 16'h0000, each 2 cycles after acceptance; flags 0.
- Decode 16'h000F -> out_word 16'h0001, out_corr=0, out_dbl=0, out_syn=0. Decode 16'h010F -> out_word 16'h0001, out_corr=1, out_syn=8, cnt_corr=1.
- Decode 16'h000E (bit 0 flipped) -> out_word 16'h0001, out_corr=1, out_syn=0. Decode 16'h000C -> out_dbl=1, out_corr=0, out_syn=1, cnt_dbl=1.
- Backpressure: 4 back-to-back words, out_ready=0 for 5 cycles -> in_ready drops once the pipe is full; out_word held stable; all 4 words delivered in order after release, none duplicated.
- CNT_W=2: 5 single-error words -> cnt_corr=3 (saturated). clr_cnt pulsed together with a 6th corr transfer -> cnt_corr=0.
- Assert rst with 2 words in flight -> out_valid=0 and counters 0 next cycle; the next word after reset is encoded/decoded correctly with 2-cycle latency.
